lcd_bus_arbiter: RTL and testbench
==================================

Name: lcd_bus_arbiter

Overview:
- Shares the single LCD_Controller Avalon-MM slave (8-bit data, 1-bit address) between N_REQ Avalon-MM write masters, e.g. the status-line display writer and the debug/message writer.
- Round-robin arbitration with a per-master lock, so a whole frame (CLEAR_DISPLAY through the last character) goes out atomically and frames from different masters never interleave.
- Sits between the display-writer modules and the LCD_Controller in the top level.

Parameters:
- N_REQ, 2, number of requesting masters (2..8).
- TIMEOUT_CYCLES, 1024, idle cycles before a locked grant is revoked. Used only with LCD_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- m_chipselect  in  N_REQ  per-master chipselect (request)
- m_write  in  N_REQ  per-master write strobe
- m_read  in  N_REQ  per-master read strobe
- m_address  in  N_REQ  per-master address (0 = instruction, 1 = data)
- m_writedata  in  8*N_REQ  per-master write data; master i occupies [8i+7:8i]
- m_lock  in  N_REQ  master holds its grant across gaps while high
- m_waitrequest  out  N_REQ  per-master waitrequest
- m_readdata  out  8  slave readdata, broadcast to all masters
- m_response  out  2  slave response, broadcast to all masters
- address  out  1  to slave
- chipselect  out  1  to slave
- byteenable  out  1  to slave; constant 1
- read  out  1  to slave
- write  out  1  to slave
- writedata  out  8  to slave
- waitrequest  in  1  from slave
- readdata  in  8  from slave
- response  in  2  from slave
- grant_valid  out  1  a master currently holds the bus
- grant_id  out  $clog2(N_REQ) (min 1)  index of the holder; 0 when no holder

Behaviour:
- States: IDLE, GRANTED. Registers: grant_id, last_id.
- Reset (async, reset_n low): state IDLE; grant_valid 0; grant_id 0; last_id N_REQ-1, so master 0 wins first; all m_waitrequest 1; chipselect, read and write 0; address 0; writedata 0x00.
- IDLE:
  - If any m_chipselect is high, take the first requesting index scanning last_id+1, last_id+2, … with wrap modulo N_REQ.
  - On the next edge: state GRANTED, grant_id = winner, grant_valid 1.
  - Arbitration latency is exactly 1 cycle. No slave strobe is driven in IDLE.
- GRANTED:
  - Slave chipselect, read, write, address and writedata are a combinational mux from master grant_id.
  - m_waitrequest[grant_id] = waitrequest. Every other m_waitrequest = 1.
  - A completed transfer is chipselect & (read | write) & !waitrequest.
- Release: on the edge where m_chipselect[grant_id] = 0 and m_lock[grant_id] = 0.
  - State goes to IDLE, last_id = grant_id, grant_valid 0.
  - A release and a new request do not overlap; the next grant needs a further IDLE cycle.
- Lock high with chipselect low: grant is held. Other requesters stall with waitrequest 1.
- A master that deasserts chipselect while waitrequest is high violates the protocol. The arbiter still releases per the rule above; no recovery is attempted.
- Requests arriving during GRANTED are not queued. They are simply re-evaluated in IDLE.
- No starvation: a master that does not drop chipselect/lock keeps the grant (see optional feature). Round-robin guarantees every requester is served within N_REQ grants once holders release.
- Reset mid-transfer: all slave strobes drop immediately (async), the grant is lost, and last_id returns to N_REQ-1.

Optional Feature:
- Macro: LCD_ARB_TIMEOUT_EN.
- Defined:
  - A counter resets to 0 on every completed transfer and on each new grant.
  - It increments every GRANTED cycle with no completed transfer.
  - When it reaches TIMEOUT_CYCLES - 1 and m_chipselect[grant_id] = 0, the grant is revoked on that edge, exactly as a release (last_id = grant_id).
  - A pending access (chipselect high) is never cut mid-transfer.
  - Output timeout_pulse (1 bit) goes high for one cycle on revocation.
- Not defined: no counter, no timeout_pulse port; the grant is held indefinitely while lock is high.

Test Plan:
- Single master: m0 writes 18 bytes with lock high, waitrequest high 1 cycle per byte. Expect the slave to see exactly 18 writes in order, grant_id 0 throughout, and m_waitrequest[1] constantly 1.
- Simultaneous request after reset: m0 and m1 assert together. Expect m0 granted first. Once m0 drops cs/lock, expect m1 granted 2 cycles later (release edge + arbitration edge).
- Round-robin: m0 and m1 each request continuously with single unlocked writes. Expect grants to alternate 0, 1, 0, 1 across 8 transfers.
- Atomic frame: m1 requests while m0 holds with lock and a 5-cycle cs gap. Expect no m1 write to reach the slave until m0 releases; m1's data then arrives intact.
- Reset mid-frame: assert reset_n low while m0 write has waitrequest high. Expect chipselect and write low in the same cycle, grant_valid 0, and master 0 winning first after reset.
- LCD_ARB_TIMEOUT_EN with TIMEOUT_CYCLES = 16: m0 holds lock with cs low. Expect revocation and a timeout_pulse 16 cycles after its last transfer, then m1 granted on the next arbitration edge.

Source files
------------

// File: rtl/lcd_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lcd_bus_arbiter
// Purpose  : Shares one LCD_Controller Avalon-MM slave between N_REQ write
//            masters. Round-robin arbitration with a per-master lock so a
//            whole display frame goes out without interleaving.
// Options  : LCD_ARB_TIMEOUT_EN - revoke an idle locked grant after
//            TIMEOUT_CYCLES cycles without a completed transfer and pulse
//            timeout_pulse on revocation.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_bus_arbiter #(
   parameter int N_REQ          = 2,
   parameter int TIMEOUT_CYCLES = 1024,
   localparam int ID_W          = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [N_REQ-1:0]   m_chipselect,
   input  logic [N_REQ-1:0]   m_write,
   input  logic [N_REQ-1:0]   m_read,
   input  logic [N_REQ-1:0]   m_address,
   input  logic [8*N_REQ-1:0] m_writedata,
   input  logic [N_REQ-1:0]   m_lock,
   output logic [N_REQ-1:0]   m_waitrequest,
   output logic [7:0]         m_readdata,
   output logic [1:0]         m_response,
   output logic               address,
   output logic               chipselect,
   output logic               byteenable,
   output logic               read,
   output logic               write,
   output logic [7:0]         writedata,
   input  logic               waitrequest,
   input  logic [7:0]         readdata,
   input  logic [1:0]         response,
   output logic               grant_valid,
   output logic [ID_W-1:0]    grant_id
`ifdef LCD_ARB_TIMEOUT_EN
   ,
   output logic               timeout_pulse
`endif
);

   // Reject out-of-range configurations at elaboration time.
   if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_params
      $error("lcd_bus_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
   end

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      GRANTED = 1'b1
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [ID_W-1:0] last_id;
   logic [ID_W-1:0] winner;
   logic            any_req;
   logic            owner_cs;
   logic            rel_normal;
   logic            rel_grant;
   logic [7:0]      wdata_arr [N_REQ];

   // Split the packed write-data bus into one byte per master.
   for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
      assign wdata_arr[i] = m_writedata[8*i +: 8];
   end

   // First requester found scanning last+1, last+2, ... modulo N_REQ.
   // Iterating from the far end lets the nearest requester overwrite.
   function automatic logic [ID_W-1:0] rr_pick(input logic [ID_W-1:0] last,
                                               input logic [N_REQ-1:0] req);
      logic [ID_W-1:0] idx;
      rr_pick = last;
      for (int k = N_REQ; k >= 1; k--) begin
         idx = ID_W'((int'(last) + k) % N_REQ);
         if (req[idx]) rr_pick = idx;
      end
   endfunction

   assign any_req     = |m_chipselect;
   assign winner      = rr_pick(last_id, m_chipselect);
   assign owner_cs    = m_chipselect[grant_id];
   assign rel_normal  = (state == GRANTED) && !owner_cs && !m_lock[grant_id];
   assign grant_valid = (state == GRANTED);
   assign byteenable  = 1'b1;
   assign m_readdata  = readdata;
   assign m_response  = response;

`ifdef LCD_ARB_TIMEOUT_EN
   localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] idle_cnt;
   logic             xfer_done;
   logic             revoke;

   assign xfer_done = chipselect && (read || write) && !waitrequest;
   // Only a locked, idle owner can be revoked; an unlocked idle owner
   // already releases normally on the same edge.
   assign revoke    = (state == GRANTED) && !owner_cs && m_lock[grant_id] &&
                      (idle_cnt == CNT_MAX);
   assign rel_grant = rel_normal || revoke;

   // Idle-cycle counter: cleared outside a grant and on each completed
   // transfer, saturating at the revocation threshold.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idle_cnt      <= '0;
         timeout_pulse <= 1'b0;
      end else begin
         timeout_pulse <= revoke;
         if (state != GRANTED || xfer_done) begin
            idle_cnt <= '0;
         end else if (idle_cnt != CNT_MAX) begin
            idle_cnt <= idle_cnt + 1'b1;
         end
      end
   end
`else
   assign rel_grant = rel_normal;
`endif

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Grant holder and round-robin pointer; last_id resets so master 0 wins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         grant_id <= '0;
         last_id  <= ID_W'(N_REQ - 1);
      end else if (state == IDLE && any_req) begin
         grant_id <= winner;
      end else if (rel_grant) begin
         last_id  <= grant_id;
         grant_id <= '0;
      end
   end

   // Next state and the slave-side mux; the holder alone sees waitrequest.
   always_comb begin
      state_next    = state;
      chipselect    = 1'b0;
      read          = 1'b0;
      write         = 1'b0;
      address       = 1'b0;
      writedata     = 8'h00;
      m_waitrequest = '1;
      case (state)
         IDLE: begin
            if (any_req) state_next = GRANTED;
         end
         GRANTED: begin
            chipselect              = owner_cs;
            read                    = m_read[grant_id];
            write                   = m_write[grant_id];
            address                 = m_address[grant_id];
            writedata               = wdata_arr[grant_id];
            m_waitrequest[grant_id] = waitrequest;
            if (rel_grant) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_lcd_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_bus_arbiter
// Purpose  : Self-checking bench for lcd_bus_arbiter (N_REQ = 2). A
//            holder-level model predicts every output each cycle; directed
//            scenarios add literal expectations and a slave write log.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_bus_arbiter;

   localparam int N = 2;
   localparam int T = 16;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [1:0]   m_cs, m_wr, m_rd, m_addr, m_lock;
   logic [15:0]  m_wdata;
   logic [1:0]   m_waitrequest;
   logic [7:0]   m_readdata;
   logic [1:0]   m_response;
   logic         address, chipselect, byteenable, read, write;
   logic [7:0]   writedata;
   logic         waitrequest;
   logic [7:0]   readdata;
   logic [1:0]   response;
   logic         grant_valid;
   logic [0:0]   grant_id;
`ifdef LCD_ARB_TIMEOUT_EN
   logic         timeout_pulse;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   // model state: who holds the bus (-1 none), who held it last
   int holder = -1;
   int last   = N - 1;
   int idle   = 0;
   bit exp_pulse = 1'b0;

   int log_q[$];     // master*256 + byte of every completed slave write
   int grant_q[$];   // grant_id at each new grant
   bit gv_prev = 1'b0;

   lcd_bus_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .reset_n(reset_n),
      .m_chipselect(m_cs), .m_write(m_wr), .m_read(m_rd),
      .m_address(m_addr), .m_writedata(m_wdata), .m_lock(m_lock),
      .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
      .m_response(m_response),
      .address(address), .chipselect(chipselect), .byteenable(byteenable),
      .read(read), .write(write), .writedata(writedata),
      .waitrequest(waitrequest), .readdata(readdata), .response(response),
      .grant_valid(grant_valid), .grant_id(grant_id)
`ifdef LCD_ARB_TIMEOUT_EN
      , .timeout_pulse(timeout_pulse)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: arbitration rules applied to the holder index.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         holder = -1; last = N - 1; idle = 0; exp_pulse = 1'b0;
      end else begin
         exp_pulse = 1'b0;
         if (holder < 0) begin
            for (int k = 1; k <= N; k++)
               if (holder < 0 && m_cs[(last + k) % N]) holder = (last + k) % N;
            idle = 0;
         end else if (!m_cs[holder] && !m_lock[holder]) begin
            last = holder; holder = -1;
         end
`ifdef LCD_ARB_TIMEOUT_EN
         else if (idle == T - 1 && !m_cs[holder]) begin
            last = holder; holder = -1; exp_pulse = 1'b1;
         end else if (m_cs[holder] && (m_wr[holder] || m_rd[holder]) && !waitrequest)
            idle = 0;
         else if (idle < T - 1)
            idle++;
`endif
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(posedge clk) begin
      #1;
      if (cmp_en && reset_n) begin
         int h;
         logic [1:0] ewr;
         h = holder;
         ewr = 2'b11;
         if (h >= 0) ewr[h] = waitrequest;
         chk("grant_valid", int'(grant_valid), (h >= 0) ? 1 : 0);
         chk("grant_id", int'(grant_id), (h >= 0) ? h : 0);
         chk("chipselect", int'(chipselect), (h >= 0) ? int'(m_cs[h]) : 0);
         chk("write", int'(write), (h >= 0) ? int'(m_wr[h]) : 0);
         chk("read", int'(read), (h >= 0) ? int'(m_rd[h]) : 0);
         chk("address", int'(address), (h >= 0) ? int'(m_addr[h]) : 0);
         chk("writedata", int'(writedata), (h >= 0) ? int'(m_wdata[8*h +: 8]) : 0);
         chk("m_waitrequest", int'(m_waitrequest), int'(ewr));
         chk("byteenable", int'(byteenable), 1);
         chk("m_readdata", int'(m_readdata), int'(readdata));
         chk("m_response", int'(m_response), int'(response));
`ifdef LCD_ARB_TIMEOUT_EN
         chk("timeout_pulse", int'(timeout_pulse), int'(exp_pulse));
`endif
      end
   end

   // Grant log: record the holder each time a grant begins.
   always @(posedge clk) begin
      #1;
      if (grant_valid && !gv_prev) grant_q.push_back(int'(grant_id));
      gv_prev = grant_valid;
   end

   // Slave write log, sampled just before the edge that completes the write.
   always @(negedge clk) begin
      readdata = 8'($urandom);
      response = 2'($urandom);
      #4;
      if (reset_n && chipselect && write && !waitrequest)
         log_q.push_back(int'(grant_id) * 256 + int'(writedata));
   end

   task automatic quiet();
      m_cs = '0; m_wr = '0; m_rd = '0; m_addr = '0; m_lock = '0;
      m_wdata = '0; waitrequest = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      quiet();
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      quiet();
      readdata = 8'h00;
      response = 2'b00;
      cmp_en = 1'b1;
      #3;
      chk("reset_grant_valid", int'(grant_valid), 0);
      chk("reset_grant_id", int'(grant_id), 0);
      chk("reset_m_waitrequest", int'(m_waitrequest), 3);
      chk("reset_chipselect", int'(chipselect), 0);
      chk("reset_writedata", int'(writedata), 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // Single master: 18 locked bytes, one wait cycle per byte.
      log_q.delete();
      m_cs[0] = 1'b1; m_lock[0] = 1'b1; m_wr[0] = 1'b1; m_addr[0] = 1'b1;
      @(posedge clk); #1;
      chk("t1_grant_valid", int'(grant_valid), 1);
      chk("t1_grant_id", int'(grant_id), 0);
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         m_wdata[7:0] = 8'(8'h40 + i);
         waitrequest = 1'b1;
         @(negedge clk);
         waitrequest = 1'b0;
      end
      @(negedge clk);
      chk("t1_m_waitrequest1", int'(m_waitrequest[1]), 1);
      quiet();
      repeat (2) @(negedge clk);
      chk("t1_write_count", log_q.size(), 18);
      for (int i = 0; i < 18 && i < log_q.size(); i++)
         chk("t1_write_byte", log_q[i], 8'h40 + i);

      // Simultaneous request after reset: m0 first, m1 two edges after drop.
      do_reset();
      m_cs = 2'b11; m_wr = 2'b11; m_wdata = 16'hB1A0;
      @(posedge clk); #1;
      chk("t2_first_grant", int'(grant_id), 0);
      chk("t2_first_valid", int'(grant_valid), 1);
      @(negedge clk);
      m_cs[0] = 1'b0; m_wr[0] = 1'b0;
      @(posedge clk); #1;
      chk("t2_release_valid", int'(grant_valid), 0);
      @(posedge clk); #1;
      chk("t2_second_valid", int'(grant_valid), 1);
      chk("t2_second_grant", int'(grant_id), 1);
      @(negedge clk);
      quiet();
      repeat (2) @(negedge clk);

      // Round-robin: both masters issue back-to-back single unlocked writes.
      begin
         bit done_prev [2];
         grant_q.delete();
         done_prev[0] = 1'b0; done_prev[1] = 1'b0;
         m_wr = 2'b11; m_wdata = 16'h2211;
         for (int c = 0; c < 200 && grant_q.size() < 9; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) m_cs[i] = !done_prev[i];
            #4;
            for (int i = 0; i < 2; i++)
               done_prev[i] = grant_valid && int'(grant_id) == i &&
                              chipselect && write && !waitrequest;
         end
         @(negedge clk);
         quiet();
         repeat (2) @(negedge clk);
         chk("t3_grant_count_ge8", (grant_q.size() >= 8) ? 1 : 0, 1);
         for (int i = 0; i < 8 && i < grant_q.size(); i++)
            chk("t3_rr_order", grant_q[i], i % 2);
      end

      // Atomic frame: m1 waits through m0's locked 5-cycle gap.
      do_reset();
      log_q.delete();
      m_cs = 2'b01; m_lock = 2'b01; m_wr = 2'b01; m_wdata = 16'h00A0;
      @(negedge clk);                       // grant m0
      m_cs[1] = 1'b1; m_wr[1] = 1'b1; m_wdata[15:8] = 8'h5B;
      @(negedge clk);                       // A0 done
      m_wdata[7:0] = 8'hA1;
      @(negedge clk);                       // A1 done
      m_cs[0] = 1'b0; m_wr[0] = 1'b0;
      repeat (5) @(negedge clk);
      m_cs[0] = 1'b1; m_wr[0] = 1'b1; m_wdata[7:0] = 8'hA2;
      @(negedge clk);                       // A2 done
      m_cs[0] = 1'b0; m_wr[0] = 1'b0; m_lock[0] = 1'b0;
      @(negedge clk);                       // release
      repeat (2) @(negedge clk);            // grant m1, its write completes
      quiet();
      repeat (2) @(negedge clk);
      chk("t4_write_count", log_q.size(), 4);
      if (log_q.size() == 4) begin
         chk("t4_byte0", log_q[0], 16'h00A0);
         chk("t4_byte1", log_q[1], 16'h00A1);
         chk("t4_byte2", log_q[2], 16'h00A2);
         chk("t4_byte3", log_q[3], 16'h015B);
      end

      // Reset mid-frame while m0's write is stalled.
      m_cs = 2'b01; m_wr = 2'b01; m_lock = 2'b01; waitrequest = 1'b1;
      m_wdata = 16'h0077;
      repeat (2) @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("t5_cs_in_reset", int'(chipselect), 0);
      chk("t5_write_in_reset", int'(write), 0);
      chk("t5_valid_in_reset", int'(grant_valid), 0);
      chk("t5_mwait_in_reset", int'(m_waitrequest), 3);
      @(negedge clk);
      reset_n = 1'b1;
      m_cs = 2'b11; m_wr = 2'b11; m_lock = 2'b00; waitrequest = 1'b0;
      @(posedge clk); #1;
      chk("t5_first_after_reset", int'(grant_id), 0);
      chk("t5_valid_after_reset", int'(grant_valid), 1);
      @(negedge clk);
      quiet();
      repeat (3) @(negedge clk);

`ifdef LCD_ARB_TIMEOUT_EN
      // Timeout: m0 keeps lock with cs low after one transfer.
      do_reset();
      m_cs = 2'b01; m_lock = 2'b01; m_wr = 2'b01;
      @(negedge clk);                       // grant m0
      @(negedge clk);                       // last transfer
      m_cs = 2'b10; m_wr = 2'b10;
      repeat (15) @(negedge clk);
      chk("t6_still_held", int'(grant_valid), 1);
      @(posedge clk); #1;
      chk("t6_revoked", int'(grant_valid), 0);
      chk("t6_pulse", int'(timeout_pulse), 1);
      @(posedge clk); #1;
      chk("t6_m1_grant", int'(grant_id), 1);
      chk("t6_pulse_once", int'(timeout_pulse), 0);
      @(negedge clk);
      quiet();
      repeat (3) @(negedge clk);
`endif

      // Randomized traffic, with occasional asynchronous resets.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         reset_n = ($urandom_range(399) != 0);
         for (int i = 0; i < 2; i++) begin
            m_cs[i]   = ($urandom_range(99) < 55);
            m_lock[i] = ($urandom_range(99) < 40);
            m_wr[i]   = ($urandom_range(99) < 70);
            m_rd[i]   = ($urandom_range(99) < 20);
            m_addr[i] = 1'($urandom);
         end
         m_wdata = 16'($urandom);
         waitrequest = ($urandom_range(99) < 40);
      end
      @(negedge clk);
      reset_n = 1'b1;
      quiet();
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
